uart_tx_scheduler: RTL and testbench
====================================

UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

Interface
REQ-001 SHALL have parameter N_REQ, default 3; number of byte requesters sharing one Uart_TX.
REQ-002 SHALL have parameter CLKS_PER_BIT, default 434; clk cycles per bit (50 MHz / 115200).
REQ-003 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port req  input  N_REQ  per-requester byte-pending flag; held high until granted.
REQ-006 SHALL have port req_data  input  8*N_REQ  byte of requester i on bits [8i+7:8i].
REQ-007 SHALL have port grant  output  N_REQ  one-hot, one-cycle acceptance pulse.
REQ-008 SHALL have port tx_start  output  1  one-cycle pulse to Uart_TX start_flag.
REQ-009 SHALL have port tx_data  output  8  byte to Uart_TX data; stable while busy.
REQ-010 SHALL have port busy  output  1  high while a frame is in flight.
REQ-011 SHALL have port tx_done  output  1  one-cycle pulse at end of frame.

Function
REQ-012 SHALL use FSM states IDLE and SEND only.
REQ-013 SHALL register every output; no combinational path from req to any output.
REQ-014 In IDLE with any req bit high at edge k, SHALL after edge k: tx_start=1, grant=one-hot winner, tx_data=winner's req_data, busy=1, counter=0, state=SEND.
REQ-015 SHALL sample req_data only at the grant edge; later req_data changes are ignored.
REQ-016 SHALL hold tx_start and grant high for exactly one cycle.
REQ-017 In SEND, SHALL increment the counter each cycle. When counter == 10*CLKS_PER_BIT-1, it SHALL pulse tx_done, clear busy and return to IDLE.
REQ-018 Frame time: tx_start to tx_done SHALL be exactly 10*CLKS_PER_BIT cycles (1 start, 8 data, 1 stop bit).
REQ-019 Back-to-back: with req pending, the next tx_start SHALL follow tx_done by exactly 1 cycle.
REQ-020 Arbitration SHALL be round-robin: search starts at last_grant+1 modulo N_REQ. last_grant updates on each grant.
REQ-021 req bits rising during SEND SHALL wait; nothing is dropped while req is held.
REQ-022 A req still high on the cycle after its grant SHALL count as a new byte.
REQ-023 Simultaneous tx_done and new req SHALL not start a frame on that edge; the start comes on the following edge.
REQ-024 The counter SHALL be wide enough for 10*CLKS_PER_BIT-1 and SHALL never wrap within a frame.

Reset
REQ-025 rst sampled high SHALL force state=IDLE, counter=0, grant=0, tx_start=0, tx_data=8'h00, busy=0, tx_done=0 and last_grant=N_REQ-1, so req[0] wins first.
REQ-026 rst mid-SEND SHALL abort the frame with no tx_done pulse. rst SHALL have priority over all other events.

Configuration
REQ-027 Macro UART_TX_SCHED_FIXED_PRIO_EN:
- Defined: fixed priority, lowest index wins; last_grant is unused.
- Undefined: round-robin per REQ-020.

Structure
REQ-028 Package uart_tx_sched_pkg SHALL hold:
- the state enum (IDLE, SEND);
- FRAME_BITS=10;
- a function for counter width from CLKS_PER_BIT.
REQ-029 Winner selection SHALL be one combinational sub-module, uart_rr_picker:
- inputs req and last_grant;
- outputs one-hot and index;
- honours the macro.

Verification (CLKS_PER_BIT=4, N_REQ=3, frame = 40 cycles)
REQ-030 Single request: req=3'b001, req_data[7:0]=8'hA5 -> tx_start and grant=001 one cycle later, tx_data=8'hA5, busy=1 for 40 cycles, tx_done on the 40th cycle.
REQ-031 All requesting: req=3'b111 held, each dropped after its grant -> grant order 001, 010, 100, with tx_start spacing 41 cycles.
REQ-032 Late request: req[1] rises at cycle 10 of a req[2] frame -> grant=010 exactly 1 cycle after tx_done.
REQ-033 Reset mid-frame: rst high at cycle 20 of a frame -> all outputs 0 next cycle, no tx_done; a re-asserted req[2] is granted 1 cycle after rst falls.
REQ-034 Macro defined: req=3'b110, then req[1] re-requests after each grant -> req[1] always wins; req[2] is never granted while req[1] is pending.
REQ-035 Data latch: req_data changes 1 cycle after grant -> tx_data is unchanged for all 40 cycles.

Source files
------------

// File: rtl/uart_tx_sched_pkg.sv
// Shared types and sizing helpers for the UART transmit scheduler.
package uart_tx_sched_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam int FRAME_BITS = 10;

  // Bits needed to count one whole frame, 0 .. FRAME_BITS*clks_per_bit-1.
  function automatic int cnt_width(input int clks_per_bit);
    int w;
    w = $clog2(FRAME_BITS * clks_per_bit);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_scheduler_picker.sv
// Combinational winner selection among pending requesters.
// UART_TX_SCHED_FIXED_PRIO_EN selects fixed lowest-index priority instead of round-robin.
module uart_rr_picker
  import uart_tx_sched_pkg::*;
#(
  parameter int N_REQ = 3,
  parameter int IDX_W = idx_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [N_REQ-1:0] onehot,
  output logic [IDX_W-1:0] idx
);

  logic             found;
  logic [IDX_W-1:0] cand;

`ifdef UART_TX_SCHED_FIXED_PRIO_EN
  logic unused_last_grant;
  assign unused_last_grant = ^last_grant;

  always_comb begin
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    cand   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = IDX_W'(i);
      if (!found && req[cand]) begin
        found        = 1'b1;
        onehot[cand] = 1'b1;
        idx          = cand;
      end
    end
  end
`else
  int pos;

  // Walk from last_grant+1 around the ring; the requester just served is checked last.
  always_comb begin
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    cand   = '0;
    pos    = 0;
    for (int off = 1; off <= N_REQ; off++) begin
      pos = int'(last_grant) + off;
      if (pos >= N_REQ) pos = pos - N_REQ;
      cand = IDX_W'(pos);
      if (!found && req[cand]) begin
        found        = 1'b1;
        onehot[cand] = 1'b1;
        idx          = cand;
      end
    end
  end
`endif

endmodule

// File: rtl/uart_tx_scheduler.sv
// Arbitrates N_REQ byte requesters onto a single Uart_TX, timing each 10-bit frame.
// UART_TX_SCHED_FIXED_PRIO_EN switches arbitration from round-robin to fixed priority.
module uart_tx_scheduler
  import uart_tx_sched_pkg::*;
#(
  parameter int N_REQ        = 3,
  parameter int CLKS_PER_BIT = 434
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [8*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]   grant,
  output logic               tx_start,
  output logic [7:0]         tx_data,
  output logic               busy,
  output logic               tx_done
);

  localparam int                 CNT_W    = cnt_width(CLKS_PER_BIT);
  localparam int                 IDX_W    = idx_width(N_REQ);
  localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(FRAME_BITS * CLKS_PER_BIT - 1);

  state_t           state, state_n;
  logic [CNT_W-1:0] counter, counter_n;
  logic [IDX_W-1:0] last_grant, last_grant_n;
  logic [IDX_W-1:0] pick_idx;
  logic [N_REQ-1:0] pick_onehot, grant_n;
  logic             tx_start_n, busy_n, tx_done_n;
  logic [7:0]       tx_data_n;

  uart_rr_picker #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_picker (
    .req        (req),
    .last_grant (last_grant),
    .onehot     (pick_onehot),
    .idx        (pick_idx)
  );

  // A grant only happens from IDLE, so a request arriving with tx_done waits one more edge.
  always_comb begin
    state_n      = state;
    counter_n    = counter;
    last_grant_n = last_grant;
    grant_n      = '0;
    tx_start_n   = 1'b0;
    tx_data_n    = tx_data;
    busy_n       = busy;
    tx_done_n    = 1'b0;
    case (state)
      IDLE: begin
        if (|req) begin
          state_n      = SEND;
          counter_n    = '0;
          grant_n      = pick_onehot;
          tx_start_n   = 1'b1;
          tx_data_n    = req_data[8*pick_idx +: 8];
          busy_n       = 1'b1;
          last_grant_n = pick_idx;
        end
      end
      SEND: begin
        if (counter == LAST_CNT) begin
          state_n   = IDLE;
          counter_n = '0;
          busy_n    = 1'b0;
          tx_done_n = 1'b1;
        end else begin
          counter_n = counter + CNT_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      counter    <= '0;
      last_grant <= IDX_W'(N_REQ - 1);
      grant      <= '0;
      tx_start   <= 1'b0;
      tx_data    <= 8'h00;
      busy       <= 1'b0;
      tx_done    <= 1'b0;
    end else begin
      state      <= state_n;
      counter    <= counter_n;
      last_grant <= last_grant_n;
      grant      <= grant_n;
      tx_start   <= tx_start_n;
      tx_data    <= tx_data_n;
      busy       <= busy_n;
      tx_done    <= tx_done_n;
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scoreboard bench for uart_tx_scheduler with N_REQ=3, CLKS_PER_BIT=4 (40-cycle frames).
module tb_uart_tx_scheduler;

  localparam int N_REQ = 3;
  localparam int CPB   = 4;
  localparam int FRAME = 10 * CPB;

  typedef struct {
    logic [2:0] g;
    logic [7:0] d;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  req = '0;
  logic [23:0] req_data = '0;
  logic [2:0]  grant;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        busy;
  logic        tx_done;

  exp_t        exp_q[$];
  logic [2:0]  sticky = '0;
  logic [7:0]  cur_data = '0;
  logic        in_frame = 1'b0;
  logic        prev_start = 1'b0;
  int          cyc = 0;
  int          start_cyc = 0;
  int          busy_run = 0;
  int          n_total = 0;
  int          n_bad = 0;

  uart_tx_scheduler #(
    .N_REQ        (N_REQ),
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_data (req_data),
    .grant    (grant),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .busy     (busy),
    .tx_done  (tx_done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s at cycle %0d: got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic pushExp(input logic [2:0] g, input logic [7:0] d);
    exp_t e;
    e.g = g;
    e.d = d;
    exp_q.push_back(e);
  endtask

  // One cycle: observe DUT outputs on the falling edge, then let granted requesters drop.
  task automatic stepCycle();
    exp_t e;
    @(negedge clk);
    cyc++;
    if (prev_start) checkOutput("start_pulse_width", 32'(tx_start), 32'd0);
    checkOutput("grant_with_start", 32'(|grant), 32'(tx_start));
    if (tx_start) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_start", 32'(grant), 32'd0);
      end else begin
        e = exp_q.pop_front();
        checkOutput("grant", 32'(grant), 32'(e.g));
        checkOutput("tx_data", 32'(tx_data), 32'(e.d));
        cur_data = e.d;
      end
      in_frame  = 1'b1;
      start_cyc = cyc;
      busy_run  = 0;
    end
    if (in_frame && busy) begin
      busy_run++;
      checkOutput("data_hold", 32'(tx_data), 32'(cur_data));
    end
    if (tx_done) begin
      if (!in_frame) begin
        checkOutput("spurious_done", 32'(tx_done), 32'd0);
      end else begin
        checkOutput("frame_len", 32'(cyc - start_cyc), 32'(FRAME));
        checkOutput("busy_len", 32'(busy_run), 32'(FRAME));
      end
      in_frame = 1'b0;
    end
    prev_start = tx_start;
    for (int i = 0; i < N_REQ; i++)
      if (grant[i] && !sticky[i]) req[i] = 1'b0;
  endtask

  task automatic waitStart(input int budget, output int at);
    at = -1;
    for (int k = 0; k < budget; k++) begin
      stepCycle();
      if (tx_start) begin
        at = cyc;
        return;
      end
    end
    checkOutput("timeout_start", 32'd0, 32'd1);
  endtask

  task automatic waitDone(input int budget, output int at);
    at = -1;
    for (int k = 0; k < budget; k++) begin
      stepCycle();
      if (tx_done) begin
        at = cyc;
        return;
      end
    end
    checkOutput("timeout_done", 32'd0, 32'd1);
  endtask

  task automatic applyStimulus(input logic [2:0] r);
    req = r;
  endtask

  task automatic resetDut();
    rst      = 1'b1;
    req      = '0;
    sticky   = '0;
    in_frame = 1'b0;
    exp_q.delete();
    stepCycle();
    stepCycle();
    checkOutput("rst_grant", 32'(grant), 32'd0);
    checkOutput("rst_tx_start", 32'(tx_start), 32'd0);
    checkOutput("rst_tx_data", 32'(tx_data), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_tx_done", 32'(tx_done), 32'd0);
    rst = 1'b0;
  endtask

  initial begin
    int s, s2, s3, d, c0;

    // Single request, data changed right after grant
    resetDut();
    req_data[7:0] = 8'hA5;
    pushExp(3'b001, 8'hA5);
    c0 = cyc;
    applyStimulus(3'b001);
    waitStart(5, s);
    checkOutput("start_latency", 32'(s - c0), 32'd1);
    req_data[7:0] = 8'h5A;
    waitDone(FRAME + 5, d);
    checkOutput("done_after_start", 32'(d - s), 32'(FRAME));
    repeat (5) stepCycle();

    // All three requesting: round-robin from reset, back-to-back spacing
    resetDut();
    req_data = {8'h33, 8'h22, 8'h11};
    pushExp(3'b001, 8'h11);
    pushExp(3'b010, 8'h22);
    pushExp(3'b100, 8'h33);
    applyStimulus(3'b111);
    waitStart(5, s);
    waitStart(FRAME + 5, s2);
    checkOutput("b2b_spacing_1", 32'(s2 - s), 32'(FRAME + 1));
    waitStart(FRAME + 5, s3);
    checkOutput("b2b_spacing_2", 32'(s3 - s2), 32'(FRAME + 1));
    waitDone(FRAME + 5, d);

    // Late request during another frame waits for tx_done
    resetDut();
    req_data = {8'hC3, 8'h77, 8'h00};
    pushExp(3'b100, 8'hC3);
    applyStimulus(3'b100);
    waitStart(5, s);
    repeat (10) stepCycle();
    pushExp(3'b010, 8'h77);
    req[1] = 1'b1;
    waitDone(FRAME + 5, d);
    waitStart(5, s2);
    checkOutput("late_after_done", 32'(s2 - d), 32'd1);
    waitDone(FRAME + 5, d);

    // Reset in the middle of a frame aborts it silently
    resetDut();
    req_data = {8'h99, 8'h00, 8'h00};
    pushExp(3'b100, 8'h99);
    applyStimulus(3'b100);
    waitStart(5, s);
    repeat (20) stepCycle();
    rst      = 1'b1;
    in_frame = 1'b0;
    req_data[23:16] = 8'h4E;
    req[2]   = 1'b1;
    stepCycle();
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_tx_start", 32'(tx_start), 32'd0);
    checkOutput("midrst_grant", 32'(grant), 32'd0);
    checkOutput("midrst_tx_data", 32'(tx_data), 32'd0);
    checkOutput("midrst_tx_done", 32'(tx_done), 32'd0);
    pushExp(3'b100, 8'h4E);
    rst = 1'b0;
    c0  = cyc;
    waitStart(5, s);
    checkOutput("regrant_after_rst", 32'(s - c0), 32'd1);
    waitDone(FRAME + 5, d);

    // req[1] re-requests continuously while req[2] waits
    resetDut();
    req_data = {8'hB2, 8'hB1, 8'h00};
    sticky   = 3'b010;
`ifdef UART_TX_SCHED_FIXED_PRIO_EN
    pushExp(3'b010, 8'hB1);
    pushExp(3'b010, 8'hB1);
    pushExp(3'b010, 8'hB1);
`else
    pushExp(3'b010, 8'hB1);
    pushExp(3'b100, 8'hB2);
    pushExp(3'b010, 8'hB1);
`endif
    applyStimulus(3'b110);
    waitStart(5, s);
    waitStart(FRAME + 5, s);
    waitStart(FRAME + 5, s);
    sticky = '0;
    req[1] = 1'b0;
`ifdef UART_TX_SCHED_FIXED_PRIO_EN
    pushExp(3'b100, 8'hB2);
    waitStart(FRAME + 5, s);
`endif
    waitDone(FRAME + 5, d);
    repeat (FRAME + 5) stepCycle();

    checkOutput("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
